regfile_read_arbiter: RTL
=========================

# regfile_read_arbiter

Shares the single 32-input, 32-bit register-file read multiplexer between four requesters (decode port A, decode port B, writeback forwarding check, debug port). It picks one request per cycle round-robin, drives the mux select from a register, captures the mux output, and returns the data tagged with the requester ID. It sits between the requesters and the read mux in the register-file read path.

## Interface
- NREQ, 4, number of requesters; fixed at 4 in this revision
- AW, 5, register address width
- DW, 32, data width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req  in  NREQ  per-requester request; held high until granted
- req_addr  in  NREQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
- gnt  out  NREQ  one-hot grant; combinational in the cycle the request wins
- stall  in  1  freezes the pipeline and suppresses all grants
- mux_sel  out  AW  registered select to the read mux
- mux_out  in  DW  read mux output; combinational from mux_sel
- rsp_valid  out  1  response valid
- rsp_id  out  2  requester index of the response
- rsp_data  out  DW  captured register value

## Operation
- Arbitration (stage A, cycle t): among asserted `req` bits, grant the first index at or after `rr_ptr`, searching upward and wrapping from 3 to 0. If `stall`=1 or `req`=0, then `gnt`=0.
- On a grant, the A→B register loads `sel_q`=addr, `id_q`=i, `v_q`=1, and `rr_ptr` becomes (i+1) mod 4. With no grant, `v_q` is loaded with 0, and `sel_q` and `rr_ptr` hold their values.
- Stage B (cycle t+1): `mux_sel`=`sel_q`. At the end of the cycle, `rsp_data` captures `mux_out`, `rsp_id`=`id_q`, and `rsp_valid`=`v_q`.
- Requesters drop `req` the cycle after seeing `gnt`. If `req` is still high, it re-arbitrates as a new request.
- Stall: every register holds (`sel_q`, `id_q`, `v_q`, `rsp_*`, `rr_ptr`). `rsp_valid` keeps its value, so an in-flight response stays presented until `stall` falls.
- No internal state machine beyond the two pipeline stages and the pointer. The pipeline states per stage are EMPTY and FULL (the `v_q` / `rsp_valid` bits).

## Timing
- Reset (rst_n=0 at a rising edge): `rr_ptr`=0, `sel_q`=0, `id_q`=0, `v_q`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0. Therefore `mux_sel`=0. While `rst_n`=0, `gnt`=0.
- Reset mid-operation: in-flight responses are discarded, with no `rsp_valid` pulse for them. The first grant after reset goes to the lowest-index asserted request.
- Latency: a grant in cycle t produces `rsp_valid` in cycle t+2.
- Throughput: one response per cycle when not stalled.
- Fairness: with all four requesting continuously, the grant order is 0,1,2,3,0,… Any single requester waits at most 3 cycles plus stall cycles.
- Simultaneous stall and request: `stall` wins, so no grant is issued and the pointer is unchanged.
- `mux_out` must settle within one cycle of `mux_sel` changing. The block adds no combinational path from `mux_out` to any output.

## Configuration
- `RDARB_R0_ZERO_EN` defined: a response for address 0 returns `rsp_data`=32'h0 regardless of `mux_out`. `mux_sel` is still driven to 0.
- `RDARB_R0_ZERO_EN` undefined: address 0 returns `mux_out` like any other register.

## Test plan
- Reset sequence:
  - Stimulus: assert rst_n=0 for 2 cycles with all req=1.
  - Required: gnt=0, rsp_valid=0, mux_sel=0.
  - Then release rst_n. Required: gnt=4'b0001 in the first cycle, rsp_valid=1 with rsp_id=0 two cycles later.
- Single request:
  - Stimulus: req=4'b0100 with addr2=5'd17, model mux_out = {27'h0,mux_sel}^32'hA5A5_0000.
  - Required: gnt=4'b0100 at t, mux_sel=17 at t+1, rsp_valid=1, rsp_id=2, rsp_data=32'hA5A5_0011 at t+2.
- Round-robin rotation:
  - Stimulus: all four requesting continuously for 8 cycles.
  - Required: grants go 0,1,2,3,0,1,2,3, and responses carry the same ID order two cycles later.
- Stall:
  - Stimulus: assert stall for 3 cycles while a response is valid and requests are pending.
  - Required: gnt=0, and rsp_valid, rsp_id and rsp_data hold. After release, the next grant is to the index after the last granted one.
- Reset mid-flight:
  - Stimulus: pulse rst_n=0 for one cycle at t+1 after a grant.
  - Required: no rsp_valid at t+2, and rr_ptr=0 afterwards.
- Address 0:
  - Stimulus: request addr=0 with mux_out=32'hDEAD_BEEF.
  - Required: rsp_data=0 with `RDARB_R0_ZERO_EN` defined, and 32'hDEAD_BEEF without it.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among four requesters,
// with a two-stage select/capture pipeline. Optional macro RDARB_R0_ZERO_EN forces reads of r0 to zero.
module regfile_read_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 5,
  parameter int unsigned DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  output logic [NREQ-1:0]      gnt_o,
  input  logic                 stall_i,
  output logic [AW-1:0]        mux_sel_o,
  input  logic [DW-1:0]        mux_out_i,
  output logic                 rsp_valid_o,
  output logic [1:0]           rsp_id_o,
  output logic [DW-1:0]        rsp_data_o
);

  localparam int unsigned IW = 2;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [AW-1:0] sel_q, sel_d;
  logic [IW-1:0] id_q, id_d;
  logic          v_q, v_d;
  logic          rsp_valid_q;
  logic [IW-1:0] rsp_id_q;
  logic [DW-1:0] rsp_data_q, cap_data;

  logic          gnt_any;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] cand;

  // Search upward from the pointer, wrapping; stall and reset suppress any grant.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_n && !stall_i) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        cand = IW'(rr_ptr_q + IW'(k));
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt_o = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

  // Stage A register inputs: load on a grant, otherwise hold select and pointer.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    id_d     = id_q;
    v_d      = gnt_any;
    if (gnt_any) begin
      rr_ptr_d = IW'(gnt_idx + IW'(1));
      sel_d    = req_addr_i[32'(gnt_idx)*AW +: AW];
      id_d     = gnt_idx;
    end
  end

`ifdef RDARB_R0_ZERO_EN
  assign cap_data = (sel_q == '0) ? '0 : mux_out_i;
`else
  assign cap_data = mux_out_i;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      id_q        <= '0;
      v_q         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else if (!stall_i) begin
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      id_q        <= id_d;
      v_q         <= v_d;
      rsp_valid_q <= v_q;
      rsp_id_q    <= id_q;
      rsp_data_q  <= cap_data;
    end
  end

  assign mux_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule
